// File: rtl/func_lut_pkg.sv
// func_lut_pkg -- shared constants and types for the programmable function selector.
//   SEL_W_DEF / WIDTH_DEF : default function-code width and lanes per table entry
//   DEPTH_DEF             : default table depth (2**SEL_W_DEF)
//   RESET_FN_DEF          : default reset function; entry i resets to {WIDTH{RESET_FN[i]}}
//   sel_t / lane_t        : function-code and table-entry types at the default sizes
package func_lut_pkg;

  localparam int SEL_W_DEF = 3;
  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 1 << SEL_W_DEF;

  localparam logic [DEPTH_DEF-1:0] RESET_FN_DEF = 8'hD9;

  typedef logic [SEL_W_DEF-1:0] sel_t;
  typedef logic [WIDTH_DEF-1:0] lane_t;

endpackage

// File: rtl/func_lut_sel_if.sv
// func_lut_sel_if -- bus bundle for func_lut_sel.
//   Config write : cfg_we, cfg_addr, cfg_data
//   Lookup in    : in_valid, in_ready, in_sel
//   Result out   : out_valid, out_ready, out_bits
//   master modport drives requests and consumes results; slave modport is the selector.
interface func_lut_sel_if #(
  parameter int SEL_W = func_lut_pkg::SEL_W_DEF,
  parameter int WIDTH = func_lut_pkg::WIDTH_DEF
) ();

  logic             cfg_we;
  logic [SEL_W-1:0] cfg_addr;
  logic [WIDTH-1:0] cfg_data;
  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] in_sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_bits;

  modport master (
    output cfg_we, cfg_addr, cfg_data, in_valid, in_sel, out_ready,
    input  in_ready, out_valid, out_bits
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, in_valid, in_sel, out_ready,
    output in_ready, out_valid, out_bits
  );

endinterface

// File: rtl/func_lut_table.sv
// func_lut_table -- DEPTH x WIDTH truth-table storage for func_lut_sel.
//   clk, rst : clock and synchronous active-high reset (loads RESET_FN pattern)
//   we       : write strobe; wrAddr/wrData select entry and new contents
//   rdAddr   : combinational read address; rdData is the current entry contents
// A write and a read of the same entry in one cycle return the old contents,
// because the read is combinational and the write lands on the clock edge.
module func_lut_table
  import func_lut_pkg::*;
#(
  parameter int                       SEL_W    = SEL_W_DEF,
  parameter int                       WIDTH    = WIDTH_DEF,
  parameter logic [(1<<SEL_W)-1:0]    RESET_FN = RESET_FN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [SEL_W-1:0] wrAddr,
  input  logic [WIDTH-1:0] wrData,
  input  logic [SEL_W-1:0] rdAddr,
  output logic [WIDTH-1:0] rdData
);

  localparam int DEPTH = 1 << SEL_W;

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: this array is reset on purpose -- its reset contents are the default
  // function table, so it must be built from flops rather than a RAM macro.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {WIDTH{RESET_FN[i]}};
      end
    end else if (we) begin
      mem[wrAddr] <= wrData;
    end
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/func_lut_sel.sv
// func_lut_sel -- programmable function selector between opcode decoder and ALU.
// A SEL_W-bit function code indexes a runtime-writable 2**SEL_W-entry table; the
// entry is returned through a one-deep registered valid/ready output stage.
//   clk        : single clock, rising edge
//   rst        : synchronous active-high reset; clears the output stage and
//                reloads the table from RESET_FN
//   bus        : func_lut_sel_if.slave (config write, lookup request, result)
//   lookup_cnt : (only with FUNC_LUT_CNT_EN defined) saturating count of
//                accepted lookups since reset
// Optional feature macro: FUNC_LUT_CNT_EN.
module func_lut_sel
  import func_lut_pkg::*;
#(
  parameter int                       SEL_W    = SEL_W_DEF,
  parameter int                       WIDTH    = WIDTH_DEF,
  parameter logic [(1<<SEL_W)-1:0]    RESET_FN = RESET_FN_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  func_lut_sel_if.slave        bus
`ifdef FUNC_LUT_CNT_EN
  ,
  output logic [15:0]          lookup_cnt
`endif
);

  logic             inReady;
  logic             accept;
  logic             transfer;
  logic             outValid;
  logic [WIDTH-1:0] outBits;
  logic [WIDTH-1:0] rdData;

  func_lut_table #(
    .SEL_W    (SEL_W),
    .WIDTH    (WIDTH),
    .RESET_FN (RESET_FN)
  ) u_table (
    .clk    (clk),
    .rst    (rst),
    .we     (bus.cfg_we),
    .wrAddr (bus.cfg_addr),
    .wrData (bus.cfg_data),
    .rdAddr (bus.in_sel),
    .rdData (rdData)
  );

  // The stage can take a new lookup whenever it is empty or its current result
  // leaves this cycle, giving full throughput with a single register.
  // NOTE: every signal driven from always_comb gets a value on every path, so no
  // latch is inferred.
  always_comb begin
    inReady  = !outValid || bus.out_ready;
    accept   = bus.in_valid && inReady;
    transfer = outValid && bus.out_ready;
  end

  // Accept wins over transfer: a simultaneous transfer+accept reloads the stage
  // and keeps out_valid high with no bubble. Stalls fall through and hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      outValid <= 1'b0;
      outBits  <= '0;
    end else if (accept) begin
      outValid <= 1'b1;
      outBits  <= rdData;
    end else if (transfer) begin
      outValid <= 1'b0;
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = outValid;
  assign bus.out_bits  = outBits;

`ifdef FUNC_LUT_CNT_EN
  logic [15:0] lookupCnt;

  // Saturates at all-ones so a long run never wraps back to a small count.
  always_ff @(posedge clk) begin
    if (rst) begin
      lookupCnt <= '0;
    end else if (accept && (lookupCnt != 16'hFFFF)) begin
      lookupCnt <= lookupCnt + 16'd1;
    end
  end

  assign lookup_cnt = lookupCnt;
`endif

endmodule

// File: tb/tb_func_lut_sel.sv
// tb_func_lut_sel -- self-checking bench for func_lut_sel (default parameters).
// Directed scenarios followed by randomized traffic, all checked against a
// behavioural model of the table and the one-deep result stage.
module tb_func_lut_sel;
  import func_lut_pkg::*;

  logic clk = 1'b0;
  logic rst;

  func_lut_sel_if bus ();

`ifdef FUNC_LUT_CNT_EN
  logic [15:0] lookupCnt;
`endif

  func_lut_sel dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave)
`ifdef FUNC_LUT_CNT_EN
    ,
    .lookup_cnt (lookupCnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: the table as an array, the output stage as "is there a
  // result waiting and what is it", plus the accepted-lookup count.
  lane_t refTable [DEPTH_DEF];
  logic  mValid;
  lane_t mBits;
  int    mCnt;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic reset_model();
    logic [DEPTH_DEF-1:0] fn;
    fn = RESET_FN_DEF;
    for (int i = 0; i < DEPTH_DEF; i++) refTable[i] = fn[i] ? 8'hFF : 8'h00;
    mValid = 1'b0;
    mBits  = '0;
    mCnt   = 0;
  endtask

  task automatic drive(input logic we, input sel_t addr, input lane_t data,
                       input logic valid, input sel_t sel, input logic ordy);
    bus.cfg_we    = we;
    bus.cfg_addr  = addr;
    bus.cfg_data  = data;
    bus.in_valid  = valid;
    bus.in_sel    = sel;
    bus.out_ready = ordy;
  endtask

  // One clock with the currently driven inputs: check in_ready before the edge,
  // advance the model, then check the registered outputs after the edge.
  task automatic cycle(input string tag);
    logic  expReady, acc, xfer, we, valid, ordy, r;
    sel_t  addr, sel;
    lane_t data;
    #1;
    we = bus.cfg_we; addr = bus.cfg_addr; data = bus.cfg_data;
    valid = bus.in_valid; sel = bus.in_sel; ordy = bus.out_ready; r = rst;
    expReady = !mValid || ordy;
    check({tag, ".in_ready"}, {31'd0, bus.in_ready}, {31'd0, expReady});
    @(posedge clk);
    #1;
    if (r) begin
      reset_model();
    end else begin
      acc  = valid && expReady;
      xfer = mValid && ordy;
      if (acc) begin
        mBits  = refTable[sel];
        mValid = 1'b1;
        if (mCnt < 65535) mCnt++;
      end else if (xfer) begin
        mValid = 1'b0;
      end
      if (we) refTable[addr] = data;
    end
    check({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, mValid});
    check({tag, ".out_bits"},  {24'd0, bus.out_bits},  {24'd0, mBits});
`ifdef FUNC_LUT_CNT_EN
    check({tag, ".lookup_cnt"}, {16'd0, lookupCnt}, mCnt);
`endif
  endtask

  initial begin
    reset_model();
    rst = 1'b1;
    // Config and lookup asserted during reset must be ignored.
    drive(1'b1, 3'd1, 8'h5A, 1'b1, 3'd2, 1'b1);
    cycle("t1_reset");
    rst = 1'b0;
    check("t1_reset_table1", {24'd0, refTable[1]}, 32'h00);

    // 1. Reset-function lookups.
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 1'b1);
    cycle("t1_sel4");
    check("t1_sel4_const", {24'd0, bus.out_bits}, 32'hFF);
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 1'b1);
    cycle("t1_sel1");
    check("t1_sel1_const", {24'd0, bus.out_bits}, 32'h00);
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd7, 1'b1);
    cycle("t1_sel7");
    check("t1_sel7_const", {24'd0, bus.out_bits}, 32'hFF);

    // 2. Config write then lookup of the written entry.
    drive(1'b1, 3'd2, 8'hA5, 1'b0, 3'd0, 1'b1);
    cycle("t2_write");
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 1'b1);
    cycle("t2_sel2");
    check("t2_sel2_const", {24'd0, bus.out_bits}, 32'hA5);
    check("t2_valid_const", {31'd0, bus.out_valid}, 32'd1);

    // 3. Stall with FF pending, then release with a queued lookup.
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 1'b1);
    cycle("t3_load");
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 1'b0);
      cycle("t3_stall");
      check("t3_stall_bits", {24'd0, bus.out_bits}, 32'hFF);
      check("t3_stall_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 1'b1);
    cycle("t3_release");
    check("t3_release_const", {24'd0, bus.out_bits}, 32'h00);

    // 4. Same-cycle write and lookup of one entry: read-before-write.
    drive(1'b1, 3'd3, 8'h00, 1'b1, 3'd3, 1'b1);
    cycle("t4_rbw");
    check("t4_rbw_const", {24'd0, bus.out_bits}, 32'hFF);
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b1);
    cycle("t4_after");
    check("t4_after_const", {24'd0, bus.out_bits}, 32'h00);

    // 5. Back-to-back lookups from a freshly reset table.
    rst = 1'b1;
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1);
    cycle("t5_reset");
    rst = 1'b0;
`ifdef FUNC_LUT_CNT_EN
    check("t5_cnt_zero", {16'd0, lookupCnt}, 32'd0);
`endif
    for (int i = 0; i < 4; i++) begin
      logic [31:0] expB2b;
      expB2b = (i == 0 || i == 3) ? 32'hFF : 32'h00;
      drive(1'b0, 3'd0, 8'h00, 1'b1, sel_t'(i), 1'b1);
      cycle("t5_b2b");
      check("t5_b2b_const", {24'd0, bus.out_bits}, expB2b);
      check("t5_b2b_valid", {31'd0, bus.out_valid}, 32'd1);
    end
`ifdef FUNC_LUT_CNT_EN
    check("t5_cnt_four", {16'd0, lookupCnt}, 32'd4);
`endif

    // 6. Reset with a result pending after table writes.
    drive(1'b1, 3'd2, 8'hA5, 1'b0, 3'd0, 1'b1);
    cycle("t6_write");
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 1'b0);
    cycle("t6_load");
    check("t6_load_const", {24'd0, bus.out_bits}, 32'hA5);
    rst = 1'b1;
    cycle("t6_reset");
    rst = 1'b0;
    check("t6_reset_valid", {31'd0, bus.out_valid}, 32'd0);
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 1'b1);
    cycle("t6_sel2");
    check("t6_sel2_const", {24'd0, bus.out_bits}, 32'h00);

    // Randomized traffic: writes, lookups, back-pressure and occasional reset.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      drive(($urandom_range(0, 3) == 0), sel_t'($urandom), lane_t'($urandom),
            ($urandom_range(0, 3) != 0), sel_t'($urandom),
            ($urandom_range(0, 2) != 0));
      cycle("rand");
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
